// File: rtl/gao_capture_core.sv
// gao_capture_core
// ----------------
// On-chip logic-analyzer capture engine. A WIDTH-bit probe bus is sampled
// into a DEPTH-entry circular buffer. A capture keeps a programmable number
// of samples before a masked level/edge trigger and fills the rest of the
// buffer after it. Once the capture completes, a bridge reads it back in
// chronological order through a registered read port.
//
// Ports:
//   clk_i         capture/sample clock
//   rstn_i        asynchronous active-low reset
//   probe_i       signals under observation
//   sample_en_i   sample qualifier (decimation); tie high for full rate
//   arm_i         single-cycle pulse, starts a capture from IDLE/DONE
//   abort_i       single-cycle pulse, returns to IDLE (wins over arm_i)
//   trig_mask_i   1 = bit participates in the trigger compare
//   trig_value_i  compare value for the masked bits
//   trig_edge_i   0 = level trigger, 1 = rising-edge-of-match trigger
//   pretrig_i     samples kept before the trigger, captured at arm
//   rd_addr_i     chronological read index, 0 = oldest sample
//   rd_data_o     read data, one cycle after rd_addr_i
//   armed_o       capture running, trigger not yet seen
//   triggered_o   trigger seen (post-fill or complete)
//   done_o        capture complete, buffer readable
//   trig_index_o  chronological index of the trigger sample
module gao_capture_core #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [WIDTH-1:0] probe_i,
  input  logic             sample_en_i,
  input  logic             arm_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] trig_mask_i,
  input  logic [WIDTH-1:0] trig_value_i,
  input  logic             trig_edge_i,
  input  logic [AW-1:0]    pretrig_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             armed_o,
  output logic             triggered_o,
  output logic             done_o,
  output logic [AW-1:0]    trig_index_o
);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_WAIT,
    ST_POST,
    ST_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    pre_cnt_q, pre_cnt_d;
  logic [AW-1:0]    post_cnt_q, post_cnt_d;
  logic [AW-1:0]    pretrig_q, pretrig_d;
  logic [AW-1:0]    trig_ptr_q, trig_ptr_d;
  logic             prev_hit_q, prev_hit_d;
  logic             armed_q, armed_d;
  logic             triggered_q, triggered_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] rd_data_q;

  logic [WIDTH-1:0] mem [DEPTH];

  logic             wr_en;
  logic             level_hit;
  logic             edge_hit;
  logic             trig_hit;
  logic [AW-1:0]    rd_phys;

  // A fully masked compare always matches, so level mode fires on the first
  // sample; edge mode is explicitly disabled then, because an always-true
  // match would otherwise look like a rising edge right after arming.
  assign level_hit = ((probe_i ^ trig_value_i) & trig_mask_i) == '0;
  assign edge_hit  = (|trig_mask_i) & level_hit & ~prev_hit_q;
  assign trig_hit  = trig_edge_i ? edge_hit : level_hit;

  // Oldest valid sample sits pretrig entries before the trigger sample;
  // the AW-bit arithmetic provides the modulo-DEPTH wrap.
  assign rd_phys = trig_ptr_q - pretrig_q + rd_addr_i;

  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    pre_cnt_d  = pre_cnt_q;
    post_cnt_d = post_cnt_q;
    pretrig_d  = pretrig_q;
    trig_ptr_d = trig_ptr_q;
    prev_hit_d = prev_hit_q;
    wr_en      = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // pretrig_i is AW bits wide, so it can never exceed DEPTH-1 and
        // the clamp is implicit.
        if (arm_i) begin
          pretrig_d  = pretrig_i;
          pre_cnt_d  = pretrig_i;
          post_cnt_d = LAST_IDX - pretrig_i;
          prev_hit_d = 1'b0;
          state_d    = (pretrig_i != '0) ? ST_PRE : ST_WAIT;
        end
      end

      ST_PRE: begin
        // The trigger is ignored here, but the match history still tracks
        // so a level already present at arm cannot pose as an edge later.
        if (sample_en_i) begin
          wr_en      = 1'b1;
          wptr_d     = wptr_q + PTR_ONE;
          prev_hit_d = level_hit;
          pre_cnt_d  = pre_cnt_q - PTR_ONE;
          if (pre_cnt_q == PTR_ONE) begin
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (sample_en_i) begin
          wr_en      = 1'b1;
          wptr_d     = wptr_q + PTR_ONE;
          prev_hit_d = level_hit;
          if (trig_hit) begin
            trig_ptr_d = wptr_q;
            state_d    = ST_POST;
          end
        end
      end

      ST_POST: begin
        // A zero count means the pre-trigger window already used every
        // other entry, so finish without waiting for another sample.
        if (post_cnt_q == '0) begin
          state_d = ST_DONE;
        end else if (sample_en_i) begin
          wr_en      = 1'b1;
          wptr_d     = wptr_q + PTR_ONE;
          post_cnt_d = post_cnt_q - PTR_ONE;
          if (post_cnt_q == PTR_ONE) begin
            state_d = ST_DONE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Abort beats everything, including a simultaneous arm, and must not
    // disturb the buffer contents.
    if (abort_i) begin
      state_d = ST_IDLE;
      wr_en   = 1'b0;
      wptr_d  = wptr_q;
    end
  end

  always_comb begin
    armed_d     = (state_d == ST_PRE)  || (state_d == ST_WAIT);
    triggered_d = (state_d == ST_POST) || (state_d == ST_DONE);
    done_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= ST_IDLE;
      wptr_q      <= '0;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      pretrig_q   <= '0;
      trig_ptr_q  <= '0;
      prev_hit_q  <= 1'b0;
      armed_q     <= 1'b0;
      triggered_q <= 1'b0;
      done_q      <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      pre_cnt_q   <= pre_cnt_d;
      post_cnt_q  <= post_cnt_d;
      pretrig_q   <= pretrig_d;
      trig_ptr_q  <= trig_ptr_d;
      prev_hit_q  <= prev_hit_d;
      armed_q     <= armed_d;
      triggered_q <= triggered_d;
      done_q      <= done_d;
      rd_data_q   <= mem[rd_phys];
    end
  end

  // Write port of the simple dual-port buffer; the RAM itself is never
  // cleared so a capture survives reset and abort.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wptr_q] <= probe_i;
    end
  end

  assign rd_data_o    = rd_data_q;
  assign armed_o      = armed_q;
  assign triggered_o  = triggered_q;
  assign done_o       = done_q;
  assign trig_index_o = pretrig_q;

endmodule

// File: tb/tb_gao_capture_core.sv
// tb_gao_capture_core
// -------------------
// Self-checking bench for gao_capture_core with WIDTH=8, DEPTH=16.
// Table-driven level-trigger captures plus hand-written sequences for the
// edge trigger, pretrig=15, abort/re-arm and asynchronous reset.
module tb_gao_capture_core;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic             clk_i = 1'b0;
  logic             rstn_i;
  logic [WIDTH-1:0] probe_i;
  logic             sample_en_i;
  logic             arm_i;
  logic             abort_i;
  logic [WIDTH-1:0] trig_mask_i;
  logic [WIDTH-1:0] trig_value_i;
  logic             trig_edge_i;
  logic [AW-1:0]    pretrig_i;
  logic [AW-1:0]    rd_addr_i;
  logic [WIDTH-1:0] rd_data_o;
  logic             armed_o;
  logic             triggered_o;
  logic             done_o;
  logic [AW-1:0]    trig_index_o;

  always #5 clk_i = ~clk_i;

  gao_capture_core #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .probe_i      (probe_i),
    .sample_en_i  (sample_en_i),
    .arm_i        (arm_i),
    .abort_i      (abort_i),
    .trig_mask_i  (trig_mask_i),
    .trig_value_i (trig_value_i),
    .trig_edge_i  (trig_edge_i),
    .pretrig_i    (pretrig_i),
    .rd_addr_i    (rd_addr_i),
    .rd_data_o    (rd_data_o),
    .armed_o      (armed_o),
    .triggered_o  (triggered_o),
    .done_o       (done_o),
    .trig_index_o (trig_index_o)
  );

  typedef struct {
    string            name;
    logic [AW-1:0]    pretrig;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] value;
    logic             edge_mode;
    bit               decim;
    logic [WIDTH-1:0] trig_sample;
    int               step;
  } vec_t;

  typedef struct {
    string       name;
    logic [63:0] expected;
  } sb_item_t;

  sb_item_t sb_q[$];

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int ev_count   = 0;
  bit auto_probe = 1'b1;
  bit decim      = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One clock: counts sample events seen by the DUT, then (in auto mode)
  // drives the probe with the cycle counter and the decimation pattern.
  task automatic applyStimulus();
    @(posedge clk_i);
    if (sample_en_i) ev_count++;
    cyc++;
    #1;
    if (auto_probe) begin
      probe_i     = WIDTH'(cyc);
      sample_en_i = decim ? (cyc % 3 == 0) : 1'b1;
    end
  endtask

  task automatic pulseAbort();
    abort_i = 1'b1;
    applyStimulus();
    abort_i = 1'b0;
  endtask

  task automatic pulseArm();
    arm_i = 1'b1;
    applyStimulus();
    arm_i = 1'b0;
    ev_count = 0;
  endtask

  // Arms so that the first post-arm sample carries the value first_sample.
  task automatic armAt(input int first_sample);
    cyc         = first_sample - 2;
    probe_i     = WIDTH'(cyc);
    sample_en_i = decim ? (cyc % 3 == 0) : 1'b1;
    applyStimulus();
    pulseArm();
  endtask

  task automatic waitDone(input string name, input int exp_events);
    int n = 0;
    while (done_o !== 1'b1 && n < 400) begin
      applyStimulus();
      n++;
    end
    checkOutput({name, " done_o"}, 64'(done_o), 64'd1);
    checkOutput({name, " sample events"}, 64'(ev_count), 64'(exp_events));
  endtask

  task automatic readout(input string name, input logic [WIDTH-1:0] exp_data [DEPTH]);
    for (int i = 0; i < DEPTH; i++) begin
      sb_item_t it;
      rd_addr_i   = AW'(i);
      it.name     = $sformatf("%s rd[%0d]", name, i);
      it.expected = 64'(exp_data[i]);
      sb_q.push_back(it);
      applyStimulus();
      it = sb_q.pop_front();
      checkOutput(it.name, 64'(rd_data_o), it.expected);
    end
  endtask

  task automatic rampReadout(input string name, input logic [WIDTH-1:0] trig_sample,
                             input int step, input int pretrig);
    logic [WIDTH-1:0] exp_data [DEPTH];
    for (int i = 0; i < DEPTH; i++) begin
      exp_data[i] = WIDTH'(int'(trig_sample) + step * (i - pretrig));
    end
    readout(name, exp_data);
  endtask

  task automatic runCapture(input vec_t v);
    trig_mask_i  = v.mask;
    trig_value_i = v.value;
    trig_edge_i  = v.edge_mode;
    pretrig_i    = v.pretrig;
    auto_probe   = 1'b1;
    decim        = v.decim;
    pulseAbort();
    armAt(int'(v.trig_sample) - v.step * int'(v.pretrig));
    checkOutput({v.name, " armed_o"}, 64'(armed_o), 64'd1);
    waitDone(v.name, DEPTH);
    checkOutput({v.name, " triggered_o"}, 64'(triggered_o), 64'd1);
    checkOutput({v.name, " armed_o done"}, 64'(armed_o), 64'd0);
    checkOutput({v.name, " trig_index_o"}, 64'(trig_index_o), 64'(v.pretrig));
    rampReadout(v.name, v.trig_sample, v.step, int'(v.pretrig));
  endtask

  function automatic vec_t mkVec(input string name, input int pretrig, input int mask,
                                 input int value, input bit dec, input int trig_sample,
                                 input int step);
    vec_t v;
    v.name        = name;
    v.pretrig     = AW'(pretrig);
    v.mask        = WIDTH'(mask);
    v.value       = WIDTH'(value);
    v.edge_mode   = 1'b0;
    v.decim       = dec;
    v.trig_sample = WIDTH'(trig_sample);
    v.step        = step;
    return v;
  endfunction

  initial begin
    vec_t vecs[5];
    vecs[0] = mkVec("level_pre4",   4, 'hFF, 'h20, 1'b0, 'h20, 1);
    vecs[1] = mkVec("level_pre0",   0, 'hFF, 'h40, 1'b0, 'h40, 1);
    vecs[2] = mkVec("mask_upper",   2, 'hF0, 'h3A, 1'b0, 'h30, 1);
    vecs[3] = mkVec("mask_zero",    0, 'h00, 'h5A, 1'b0, 'h05, 1);
    vecs[4] = mkVec("decimate3",    4, 'hFF, 'h60, 1'b1, 'h60, 3);

    rstn_i       = 1'b0;
    probe_i      = '0;
    sample_en_i  = 1'b1;
    arm_i        = 1'b0;
    abort_i      = 1'b0;
    trig_mask_i  = '0;
    trig_value_i = '0;
    trig_edge_i  = 1'b0;
    pretrig_i    = '0;
    rd_addr_i    = '0;

    applyStimulus();
    applyStimulus();
    checkOutput("reset armed_o", 64'(armed_o), 64'd0);
    checkOutput("reset triggered_o", 64'(triggered_o), 64'd0);
    checkOutput("reset done_o", 64'(done_o), 64'd0);
    checkOutput("reset trig_index_o", 64'(trig_index_o), 64'd0);
    checkOutput("reset rd_data_o", 64'(rd_data_o), 64'd0);
    rstn_i = 1'b1;
    applyStimulus();

    for (int k = 0; k < 5; k++) begin
      runCapture(vecs[k]);
    end

    // pretrig=15: the whole buffer is pre-trigger, done follows the hit.
    begin
      int n = 0;
      trig_mask_i  = 8'hFF;
      trig_value_i = 8'h70;
      trig_edge_i  = 1'b0;
      pretrig_i    = 4'd15;
      auto_probe   = 1'b1;
      decim        = 1'b0;
      pulseAbort();
      armAt(8'h70 - 15);
      while (triggered_o !== 1'b1 && n < 40) begin
        applyStimulus();
        n++;
      end
      checkOutput("pre15 triggered_o", 64'(triggered_o), 64'd1);
      checkOutput("pre15 events at hit", 64'(ev_count), 64'd16);
      checkOutput("pre15 done_o at hit", 64'(done_o), 64'd0);
      applyStimulus();
      checkOutput("pre15 done_o next", 64'(done_o), 64'd1);
      checkOutput("pre15 trig_index_o", 64'(trig_index_o), 64'd15);
      rampReadout("pre15", 8'h70, 1, 15);
    end

    // Edge trigger: bit0 already high at arm must not fire; the first
    // 0->1 transition does.
    begin
      logic [WIDTH-1:0] exp_data [DEPTH];
      trig_mask_i  = 8'h01;
      trig_value_i = 8'h01;
      trig_edge_i  = 1'b1;
      pretrig_i    = 4'd4;
      auto_probe   = 1'b0;
      sample_en_i  = 1'b1;
      probe_i      = 8'h81;
      pulseAbort();
      pulseArm();
      for (int k = 0; k < 8; k++) applyStimulus();
      checkOutput("edge held-high no trig", 64'(triggered_o), 64'd0);
      probe_i = 8'h10;
      for (int k = 0; k < 3; k++) applyStimulus();
      checkOutput("edge low no trig", 64'(triggered_o), 64'd0);
      probe_i = 8'h23;
      applyStimulus();
      checkOutput("edge rise trig", 64'(triggered_o), 64'd1);
      for (int k = 0; k < 11; k++) begin
        probe_i = WIDTH'(8'h40 + k);
        applyStimulus();
      end
      waitDone("edge", 23);
      exp_data[0] = 8'h81;
      exp_data[1] = 8'h10;
      exp_data[2] = 8'h10;
      exp_data[3] = 8'h10;
      exp_data[4] = 8'h23;
      for (int i = 5; i < DEPTH; i++) exp_data[i] = WIDTH'(8'h40 + i - 5);
      readout("edge", exp_data);
    end

    // Edge mode with an empty mask never fires; abort from WAIT clears flags;
    // arm together with abort stays idle.
    trig_mask_i  = 8'h00;
    trig_edge_i  = 1'b1;
    pretrig_i    = 4'd0;
    auto_probe   = 1'b1;
    decim        = 1'b0;
    pulseAbort();
    pulseArm();
    for (int k = 0; k < 20; k++) applyStimulus();
    checkOutput("edge mask0 no trig", 64'(triggered_o), 64'd0);
    checkOutput("edge mask0 armed_o", 64'(armed_o), 64'd1);
    pulseAbort();
    checkOutput("abort armed_o", 64'(armed_o), 64'd0);
    checkOutput("abort triggered_o", 64'(triggered_o), 64'd0);
    checkOutput("abort done_o", 64'(done_o), 64'd0);
    arm_i   = 1'b1;
    abort_i = 1'b1;
    applyStimulus();
    arm_i   = 1'b0;
    abort_i = 1'b0;
    checkOutput("arm+abort armed_o", 64'(armed_o), 64'd0);
    applyStimulus();
    checkOutput("arm+abort still idle", 64'(armed_o), 64'd0);

    // arm_i during POST is ignored and the capture completes unchanged.
    trig_mask_i  = 8'hFF;
    trig_value_i = 8'h20;
    trig_edge_i  = 1'b0;
    pretrig_i    = 4'd0;
    pulseAbort();
    armAt(8'h20);
    applyStimulus();
    checkOutput("post-arm triggered_o", 64'(triggered_o), 64'd1);
    applyStimulus();
    applyStimulus();
    arm_i = 1'b1;
    applyStimulus();
    arm_i = 1'b0;
    checkOutput("arm in POST armed_o", 64'(armed_o), 64'd0);
    checkOutput("arm in POST triggered_o", 64'(triggered_o), 64'd1);
    waitDone("arm in POST", DEPTH);
    rampReadout("arm in POST", 8'h20, 1, 0);

    // Asynchronous reset in POST, then a fresh capture.
    begin
      int n = 0;
      pretrig_i = 4'd3;
      pulseAbort();
      armAt(8'h20 - 3);
      while (triggered_o !== 1'b1 && n < 40) begin
        applyStimulus();
        n++;
      end
      applyStimulus();
      checkOutput("pre-reset triggered_o", 64'(triggered_o), 64'd1);
      #2 rstn_i = 1'b0;
      #1;
      checkOutput("async reset triggered_o", 64'(triggered_o), 64'd0);
      checkOutput("async reset armed_o", 64'(armed_o), 64'd0);
      checkOutput("async reset done_o", 64'(done_o), 64'd0);
      checkOutput("async reset trig_index_o", 64'(trig_index_o), 64'd0);
      checkOutput("async reset rd_data_o", 64'(rd_data_o), 64'd0);
      #10 rstn_i = 1'b1;
      runCapture(mkVec("after reset", 6, 'hFF, 'h50, 1'b0, 'h50, 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
